// File: rtl/ne16_scale_ctrl_if.sv
// Scale-stream bundle between the NE16 scale controller and its datapath.
// The controller owns enable/shift/invert; the datapath reports valid/ready.
interface ne16_scale_ctrl_if #(
  parameter int N_SHIFTS = 8
);
  logic                        beat_valid_i;
  logic                        beat_ready_i;
  logic                        enable_o;
  logic [$clog2(N_SHIFTS)-1:0] shift_sel_o;
  logic                        invert_o;

  modport master (
    input  beat_valid_i,
    input  beat_ready_i,
    output enable_o,
    output shift_sel_o,
    output invert_o
  );

  modport slave (
    output beat_valid_i,
    output beat_ready_i,
    input  enable_o,
    input  shift_sel_o,
    input  invert_o
  );
endinterface

// File: rtl/ne16_scale_ctrl.sv
// NE16 scale controller: walks weight bit-planes per group and counts groups.
// Drives shift/invert selection to the scale datapath from registers only.
module ne16_scale_ctrl #(
  parameter int N_SHIFTS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [$clog2(N_SHIFTS):0]     qw_i,
  input  logic                          signed_i,
  input  logic [CNT_W-1:0]              n_iter_i,
  ne16_scale_ctrl_if.master             scale,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CNT_W-1:0]              iter_cnt_o
);

  localparam int SEL_W = $clog2(N_SHIFTS);
  localparam int QW_W  = SEL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_d, state_q;
  logic [SEL_W-1:0] bit_cnt_d, bit_cnt_q;
  logic [CNT_W-1:0] iter_cnt_d, iter_cnt_q;
  logic [QW_W-1:0]  qw_d, qw_q;
  logic             signed_d, signed_q;
  logic [CNT_W-1:0] n_iter_d, n_iter_q;

  logic [QW_W-1:0]  qw_sat;
  logic [QW_W-1:0]  qw_last;
  logic             bit_last;
  logic             beat;
  logic [CNT_W-1:0] iter_inc;

  // Out-of-range widths clamp into 1..N_SHIFTS so the bit walk always ends.
  always_comb begin
    qw_sat = qw_i;
    if (qw_i == '0) begin
      qw_sat = QW_W'(1);
    end else if (qw_i > QW_W'(N_SHIFTS)) begin
      qw_sat = QW_W'(N_SHIFTS);
    end
  end

  assign qw_last  = qw_q - QW_W'(1);
  assign bit_last = ({1'b0, bit_cnt_q} == qw_last);
  assign beat     = (state_q == S_RUN) &
                    scale.beat_valid_i &
                    scale.beat_ready_i;
  assign iter_inc = iter_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    iter_cnt_d = iter_cnt_q;
    qw_d       = qw_q;
    signed_d   = signed_q;
    n_iter_d   = n_iter_q;
    if (clear_i) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      iter_cnt_d = '0;
      qw_d       = '0;
      signed_d   = 1'b0;
      n_iter_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            qw_d       = qw_sat;
            signed_d   = signed_i;
            n_iter_d   = n_iter_i;
            bit_cnt_d  = '0;
            iter_cnt_d = '0;
            state_d    = (n_iter_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (beat) begin
            if (bit_last) begin
              bit_cnt_d  = '0;
              iter_cnt_d = iter_inc;
              if (iter_inc == n_iter_q) begin
                state_d = S_DONE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + SEL_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      iter_cnt_q <= '0;
      qw_q       <= '0;
      signed_q   <= 1'b0;
      n_iter_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      qw_q       <= qw_d;
      signed_q   <= signed_d;
      n_iter_q   <= n_iter_d;
    end
  end

  assign scale.enable_o    = (state_q == S_RUN);
  assign scale.shift_sel_o = bit_cnt_q;
  assign scale.invert_o    = signed_q & bit_last;
  assign busy_o            = (state_q == S_RUN);
  assign done_o            = (state_q == S_DONE);
  assign iter_cnt_o        = iter_cnt_q;

endmodule

// File: tb/tb_ne16_scale_ctrl.sv
// Directed bench for ne16_scale_ctrl: bit-plane walk, stalls, edge cases.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ne16_scale_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [3:0]  qw_i;
  logic        signed_i;
  logic [15:0] n_iter_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] iter_cnt_o;

  int checks;
  int errors;

  ne16_scale_ctrl_if #(.N_SHIFTS(8)) scale_if ();

  ne16_scale_ctrl #(
    .N_SHIFTS(8),
    .CNT_W   (16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .start_i   (start_i),
    .qw_i      (qw_i),
    .signed_i  (signed_i),
    .n_iter_i  (n_iter_i),
    .scale     (scale_if.master),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .iter_cnt_o(iter_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] qw, input logic sg,
                        input logic [15:0] n);
    qw_i     = qw;
    signed_i = sg;
    n_iter_i = n;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    qw_i = 4'd0;
    signed_i = 1'b0;
    n_iter_i = 16'd0;
    scale_if.beat_valid_i = 1'b0;
    scale_if.beat_ready_i = 1'b0;
    step();
    step();
    checks++;
    if ({scale_if.enable_o, busy_o, done_o, scale_if.invert_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {scale_if.enable_o, busy_o, done_o, scale_if.invert_o});
    end
    checks++;
    if (scale_if.shift_sel_o !== 3'd0 || iter_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got sel %0d iter %0d exp 0 0",
               scale_if.shift_sel_o, iter_cnt_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic();
    scale_if.beat_valid_i = 1'b1;
    scale_if.beat_ready_i = 1'b1;
    launch(4'd4, 1'b1, 16'd2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (scale_if.enable_o !== 1'b1 ||
          scale_if.shift_sel_o !== 3'(i % 4) ||
          scale_if.invert_o !== (i % 4 == 3) ||
          iter_cnt_o !== 16'(i / 4) || done_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d got en %b sel %0d inv %b it %0d dn %b",
                 i, scale_if.enable_o, scale_if.shift_sel_o,
                 scale_if.invert_o, iter_cnt_o, done_o);
      end
      step();
    end
    checks++;
    if (done_o !== 1'b1 || scale_if.enable_o !== 1'b0 ||
        iter_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL basic_done got dn %b en %b it %0d exp 1 0 2",
               done_o, scale_if.enable_o, iter_cnt_o);
    end
    step();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || iter_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL basic_idle got dn %b bz %b it %0d exp 0 0 2",
               done_o, busy_o, iter_cnt_o);
    end
  endtask

  task automatic test_stall();
    logic [2:0] exp_sel [5];
    exp_sel = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    scale_if.beat_valid_i = 1'b1;
    scale_if.beat_ready_i = 1'b1;
    launch(4'd3, 1'b0, 16'd1);
    for (int c = 0; c < 5; c++) begin
      scale_if.beat_ready_i = (c % 2 == 0);
      checks++;
      if (scale_if.shift_sel_o !== exp_sel[c] ||
          scale_if.invert_o !== 1'b0 || done_o !== 1'b0 ||
          busy_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_c%0d got sel %0d inv %b dn %b bz %b exp sel %0d",
                 c, scale_if.shift_sel_o, scale_if.invert_o, done_o,
                 busy_o, exp_sel[c]);
      end
      step();
    end
    checks++;
    if (done_o !== 1'b1 || iter_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL stall_done got dn %b it %0d exp 1 1", done_o, iter_cnt_o);
    end
    scale_if.beat_ready_i = 1'b1;
    step();
  endtask

  task automatic test_zero_iter();
    launch(4'd4, 1'b1, 16'd0);
    checks++;
    if (done_o !== 1'b1 || scale_if.enable_o !== 1'b0 ||
        iter_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL zero_done got dn %b en %b it %0d exp 1 0 0",
               done_o, scale_if.enable_o, iter_cnt_o);
    end
    step();
    checks++;
    if (done_o !== 1'b0 || scale_if.enable_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle got dn %b en %b exp 0 0",
               done_o, scale_if.enable_o);
    end
  endtask

  task automatic test_qw_sat();
    launch(4'd0, 1'b1, 16'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (scale_if.shift_sel_o !== 3'd0 || scale_if.invert_o !== 1'b1 ||
          iter_cnt_o !== 16'(i)) begin
        errors++;
        $display("FAIL qw0_beat%0d got sel %0d inv %b it %0d",
                 i, scale_if.shift_sel_o, scale_if.invert_o, iter_cnt_o);
      end
      step();
    end
    checks++;
    if (done_o !== 1'b1 || iter_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL qw0_done got dn %b it %0d exp 1 2", done_o, iter_cnt_o);
    end
    step();
    launch(4'd12, 1'b1, 16'd1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (scale_if.shift_sel_o !== 3'(i) || scale_if.invert_o !== (i == 7) ||
          done_o !== 1'b0) begin
        errors++;
        $display("FAIL qw12_beat%0d got sel %0d inv %b dn %b",
                 i, scale_if.shift_sel_o, scale_if.invert_o, done_o);
      end
      step();
    end
    checks++;
    if (done_o !== 1'b1 || iter_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL qw12_done got dn %b it %0d exp 1 1", done_o, iter_cnt_o);
    end
    step();
  endtask

  task automatic test_clear();
    launch(4'd2, 1'b0, 16'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) clear_i = 1'b1;
      step();
    end
    clear_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || iter_cnt_o !== 16'd0 ||
        scale_if.shift_sel_o !== 3'd0) begin
      errors++;
      $display("FAIL clear_state got bz %b dn %b it %0d sel %0d exp 0 0 0 0",
               busy_o, done_o, iter_cnt_o, scale_if.shift_sel_o);
    end
    step();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_nodone got dn %b exp 0", done_o);
    end
    launch(4'd1, 1'b0, 16'd1);
    checks++;
    if (scale_if.enable_o !== 1'b1 || scale_if.shift_sel_o !== 3'd0) begin
      errors++;
      $display("FAIL clear_restart got en %b sel %0d exp 1 0",
               scale_if.enable_o, scale_if.shift_sel_o);
    end
    step();
    checks++;
    if (done_o !== 1'b1 || iter_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL clear_redone got dn %b it %0d exp 1 1", done_o, iter_cnt_o);
    end
    step();
  endtask

  task automatic test_start_busy();
    launch(4'd2, 1'b1, 16'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (scale_if.shift_sel_o !== 3'(i) || scale_if.invert_o !== (i == 1) ||
          busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_beat%0d got sel %0d inv %b bz %b",
                 i, scale_if.shift_sel_o, scale_if.invert_o, busy_o);
      end
      start_i  = (i == 0);
      qw_i     = 4'd8;
      signed_i = 1'b0;
      n_iter_i = 16'd5;
      step();
    end
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || iter_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL busy_done got dn %b it %0d exp 1 1", done_o, iter_cnt_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    launch(4'd4, 1'b1, 16'd2);
    step();
    step();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({scale_if.enable_o, busy_o, done_o, scale_if.invert_o} !== 4'b0 ||
        scale_if.shift_sel_o !== 3'd0 || iter_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_async got f %b sel %0d it %0d exp 0000 0 0",
               {scale_if.enable_o, busy_o, done_o, scale_if.invert_o},
               scale_if.shift_sel_o, iter_cnt_o);
    end
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle%0d got bz %b dn %b exp 0 0",
                 i, busy_o, done_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_iter();
    test_qw_sat();
    test_clear();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
